// File: rtl/sdff_rr_arbiter_if.sv
// Handshake bundle between the requesters and the round-robin write arbiter.
// Requesters drive req/wdata/clr; the arbiter returns grant, owner and the shared register.
interface sdff_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 2
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*WIDTH-1:0]   wdata;
  logic [N_REQ-1:0]         clr;
  logic [N_REQ-1:0]         gnt;
  logic [$clog2(N_REQ)-1:0] owner;
  logic [WIDTH-1:0]         q;
  logic                     q_vld;

  modport master (output req, wdata, clr, input gnt, owner, q, q_vld);
  modport slave  (input req, wdata, clr, output gnt, owner, q, q_vld);
endinterface

// File: rtl/sdff_rr_arbiter.sv
// Round-robin arbiter sharing one sync-reset register; grant 1 cycle after req, first write the cycle after.
// Tenure capped at MAX_HOLD writes under contention; handoff is back-to-back with no idle cycle.
module sdff_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              srst,
  sdff_rr_arbiter_if.slave  bus
);
  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_n;
  logic [N_REQ-1:0]  gnt, gnt_n;
  logic [OW-1:0]     owner, owner_n;
  logic [OW-1:0]     last, last_n;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic [WIDTH-1:0]  q, q_n;
  logic              q_vld, q_vld_n;

  logic              own_req;
  logic              release_now;
  logic [N_REQ-1:0]  others;

  // First set bit of m scanning ptr+1, ptr+2, ... with wraparound.
  function automatic logic [OW-1:0] pick(input logic [N_REQ-1:0] m, input logic [OW-1:0] ptr);
    logic          found;
    logic [OW-1:0] idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = OW'((int'(ptr) + k) % N_REQ);
      if (!found && m[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] w);
    onehot    = '0;
    onehot[w] = 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      last     <= OW'(N_REQ - 1);
      hold_cnt <= '0;
      q        <= '0;
      q_vld    <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      owner    <= owner_n;
      last     <= last_n;
      hold_cnt <= hold_n;
      q        <= q_n;
      q_vld    <= q_vld_n;
    end
  end

  assign own_req     = bus.req[owner];
  assign release_now = !own_req || (hold_cnt == HW'(MAX_HOLD - 1));
  assign others      = bus.req & ~onehot(owner);

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    last_n  = last;
    hold_n  = hold_cnt;
    q_n     = q;
    q_vld_n = q_vld;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          owner_n = pick(bus.req, last);
          gnt_n   = onehot(owner_n);
          hold_n  = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        // Only the owner's controls matter; clear wins over write.
        if (own_req) begin
          if (bus.clr[owner]) begin
            q_n     = '0;
            q_vld_n = 1'b0;
          end else begin
            q_n     = bus.wdata[int'(owner)*WIDTH +: WIDTH];
            q_vld_n = 1'b1;
          end
        end
        if (release_now) begin
          last_n = owner;
          hold_n = '0;
          if (|others) begin
            owner_n = pick(others, owner);
            gnt_n   = onehot(owner_n);
          end else if (!own_req) begin
            gnt_n   = '0;
            state_n = IDLE;
          end
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.gnt   = gnt;
  assign bus.owner = owner;
  assign bus.q     = q;
  assign bus.q_vld = q_vld;
endmodule

// File: tb/tb_sdff_rr_arbiter.sv
// Directed bench for sdff_rr_arbiter: reset, contention rotation, hold expiry, clear priority, reset mid-tenure.
module tb_sdff_rr_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 2;

  logic clk = 1'b0;
  logic srst;
  int   checks = 0;
  int   errors = 0;

  sdff_rr_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus();

  sdff_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_HOLD(4)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it; inputs set afterwards are stable for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N_REQ-1:0] exp_gnt;
    int               own;

    srst      = 1'b1;
    bus.req   = 4'b1111;
    bus.clr   = 4'b0000;
    bus.wdata = 8'b11_10_01_00;
    tick();
    tick();
    chk("rst_gnt",   32'(bus.gnt),   32'h0);
    chk("rst_q",     32'(bus.q),     32'h0);
    chk("rst_vld",   32'(bus.q_vld), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);

    // Contention: owners 0,1,2,3,0 each for 4 cycles, Q trails by one cycle.
    srst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      own     = (n / 4) % 4;
      exp_gnt = 4'b0001 << own;
      chk($sformatf("rr_gnt%0d", n),   32'(bus.gnt),   32'(exp_gnt));
      chk($sformatf("rr_owner%0d", n), 32'(bus.owner), 32'(own));
      if (n == 0) begin
        chk("rr_q_first", 32'(bus.q),     32'h0);
        chk("rr_vld0",    32'(bus.q_vld), 32'h0);
      end else begin
        chk($sformatf("rr_q%0d", n), 32'(bus.q), 32'(((n - 1) / 4) % 4));
        chk($sformatf("rr_vld%0d", n), 32'(bus.q_vld), 32'h1);
      end
    end

    // Single requester: grant, write every cycle through hold expiry, then drop.
    srst    = 1'b1;
    bus.req = 4'b0000;
    tick();
    srst      = 1'b0;
    bus.req   = 4'b0100;
    bus.wdata = 8'b00_10_00_00;
    tick();
    chk("single_gnt",  32'(bus.gnt),   32'b0100);
    chk("single_q0",   32'(bus.q),     32'h0);
    chk("single_vld0", 32'(bus.q_vld), 32'h0);
    tick();
    chk("single_q",    32'(bus.q),     32'b10);
    chk("single_vld",  32'(bus.q_vld), 32'h1);
    for (int c = 0; c < 10; c++) begin
      bus.wdata = 8'(c % 4) << 4;
      tick();
      chk($sformatf("hold_gnt%0d", c), 32'(bus.gnt), 32'b0100);
      chk($sformatf("hold_q%0d", c),   32'(bus.q),   32'(c % 4));
    end
    bus.req = 4'b0000;
    tick();
    chk("drop_gnt", 32'(bus.gnt),   32'h0);
    chk("drop_q",   32'(bus.q),     32'h1);
    chk("drop_vld", 32'(bus.q_vld), 32'h1);

    // Clear priority and non-owner clears.
    bus.req   = 4'b0010;
    bus.wdata = 8'b00_00_11_00;
    bus.clr   = 4'b1000;
    tick();
    chk("clr_gnt", 32'(bus.gnt), 32'b0010);
    tick();
    chk("clr_nonown_q",   32'(bus.q),     32'b11);
    chk("clr_nonown_vld", 32'(bus.q_vld), 32'h1);
    bus.clr = 4'b0010;
    tick();
    chk("clr_own_q",   32'(bus.q),     32'h0);
    chk("clr_own_vld", 32'(bus.q_vld), 32'h0);
    bus.wdata = 8'b00_00_01_00;
    bus.clr   = 4'b1000;
    tick();
    chk("clr_rewrite_q", 32'(bus.q), 32'b01);
    bus.req = 4'b0000;
    bus.clr = 4'b0010;
    tick();
    chk("clr_noreq_q",   32'(bus.q),     32'b01);
    chk("clr_noreq_vld", 32'(bus.q_vld), 32'h1);
    chk("clr_noreq_gnt", 32'(bus.gnt),   32'h0);

    // Reset during owner 3's second cycle; pointer returns to N_REQ-1 so 0 wins next.
    bus.clr   = 4'b0000;
    bus.req   = 4'b1000;
    bus.wdata = 8'b10_00_00_11;
    tick();
    chk("mid_gnt3", 32'(bus.gnt), 32'b1000);
    tick();
    chk("mid_q3", 32'(bus.q), 32'b10);
    srst = 1'b1;
    tick();
    chk("mid_rst_gnt", 32'(bus.gnt),   32'h0);
    chk("mid_rst_q",   32'(bus.q),     32'h0);
    chk("mid_rst_vld", 32'(bus.q_vld), 32'h0);
    srst    = 1'b0;
    bus.req = 4'b1001;
    tick();
    chk("mid_win0",  32'(bus.gnt),   32'b0001);
    chk("mid_own0",  32'(bus.owner), 32'h0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("mid_keep0_%0d", n), 32'(bus.gnt), 32'b0001);
    end
    tick();
    chk("mid_hand3",  32'(bus.gnt),   32'b1000);
    chk("mid_hand_q", 32'(bus.q),     32'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
